cdc_handshake_src_ctrl: RTL and testbench
=========================================

Name: cdc_handshake_src_ctrl

Overview:
- Source-side controller for a 4-phase REQ/ACK clock-domain-crossing channel.
- Accepts words from a local valid/ready producer and holds each word stable on XFER_DATA.
- Sequences XFER_REQ against an ACK arriving asynchronously from the destination domain, which is synchronized internally.
- Detects a stalled destination with a timeout and counts completed transfers; it is the block that drives the crossing between two free-running clocks in our CDC benches and designs.

Parameters:
DATA_WIDTH, 8, width of the transferred word
SYNC_STAGES, 2, flops in the ACK synchronizer (legal range 2..4)
TIMEOUT_CYCLES, 1024, CLK cycles allowed per handshake phase before error (>=4)
COUNT_WIDTH, 16, width of the completed-transfer counter

Ports:
CLK  input  1  source-domain clock
RESET_N  input  1  asynchronous, active-low reset
IN_VALID  input  1  producer has a word
IN_DATA  input  DATA_WIDTH  producer word
IN_READY  output  1  controller can accept a word this cycle
XFER_DATA  output  DATA_WIDTH  captured word, stable from REQ rise until ACK is seen low
XFER_REQ  output  1  registered request to destination domain
XFER_ACK_ASYNC  input  1  acknowledge from destination domain, asynchronous to CLK
ERR_CLEAR  input  1  single-cycle pulse, clears the timeout error
TIMEOUT_ERR  output  1  sticky, set on handshake timeout
BUSY  output  1  high whenever state is not IDLE
XFER_COUNT  output  COUNT_WIDTH  completed transfers, wraps modulo 2^COUNT_WIDTH

Behaviour:
- One clock domain (CLK); RESET_N asynchronous, active-low. Asserting it forces all registers to reset at once, including the synchronizer flops.
- Reset values: XFER_REQ=0, XFER_DATA=0, TIMEOUT_ERR=0, XFER_COUNT=0, state=IDLE, timer=0. IN_READY=1 and BUSY=0 follow from IDLE.
- ACK path: XFER_ACK_ASYNC passes through a SYNC_STAGES flop chain; ack_s is the last stage. Only ack_s is used by any logic.
- IN_READY = (state==IDLE); BUSY = (state!=IDLE). Both are decoded from the state register only, with no input-to-output combinational path.
- IDLE: on IN_VALID&IN_READY at edge N, capture IN_DATA into XFER_DATA, set XFER_REQ=1 (visible after edge N), go to WAIT_ACK_HI.
- WAIT_ACK_HI: on ack_s=1, clear XFER_REQ and go to WAIT_ACK_LO. XFER_DATA is not modified.
- WAIT_ACK_LO: on ack_s=0, increment XFER_COUNT (wraps at all-ones) and go to IDLE. XFER_DATA is held until this transition.
- Timeout: the phase timer clears on every state entry and increments each cycle in WAIT_ACK_HI/WAIT_ACK_LO. When the timer equals TIMEOUT_CYCLES-1 and the awaited ack_s level is not present in that same cycle:
  - go to ERROR;
  - set TIMEOUT_ERR=1 and force XFER_REQ=0;
  - do not increment XFER_COUNT.
  - If the awaited level arrives in that same cycle, the handshake transition wins.
- ERROR: IN_READY=0, XFER_REQ=0. Exit to IDLE only when ERR_CLEAR=1 and ack_s=0 in the same cycle; TIMEOUT_ERR clears on that edge. ERR_CLEAR in any other state is ignored.
- Minimum handshake time with an immediate-loopback destination: REQ high for SYNC_STAGES+1 cycles, then low for SYNC_STAGES+1 cycles. The next accept is possible on the cycle after returning to IDLE.
- IN_DATA/IN_VALID changes outside IDLE have no effect. Any producer word not accepted stays the producer's responsibility.
- Reset mid-transfer: REQ drops immediately (asynchronously) and the in-flight word is lost. The counter is not incremented.
- Width rule: the timer is clog2(TIMEOUT_CYCLES) bits and never wraps.

Decomposition:
- Shared package cdc_ctrl_pkg holds:
  - the state enum (IDLE, WAIT_ACK_HI, WAIT_ACK_LO, ERROR; 2-bit encoding);
  - the default SYNC_STAGES and TIMEOUT_CYCLES constants.
- One sub-module, sync_ff_chain (parameter STAGES, single-bit, async active-low reset). It is reused for the destination-side REQ synchronizer later.

Test Plan:
- Loopback with 3-cycle destination delay, SYNC_STAGES=2, send 0xA5:
  - XFER_REQ rises the cycle after accept;
  - XFER_DATA=0xA5 holds until ack_s falls;
  - XFER_COUNT 0->1;
  - IN_READY returns to 1.
- IN_VALID held high with words 0x01..0x08 under immediate loopback -> 8 handshakes in order, XFER_COUNT=8, no data change while BUSY.
- XFER_ACK_ASYNC tied 0, TIMEOUT_CYCLES=16 -> TIMEOUT_ERR=1 exactly 16 cycles after REQ rise, XFER_REQ=0, IN_READY=0, count unchanged.
- From ERROR, pulse ERR_CLEAR while ACK is high -> stays in ERROR. Drop ACK, wait for ack_s=0, pulse ERR_CLEAR -> IDLE, TIMEOUT_ERR=0.
- Assert RESET_N=0 during WAIT_ACK_HI with ACK toggling -> all outputs at reset values immediately. After release, a new 0x3C transfer completes normally.
- COUNT_WIDTH=2, 5 transfers -> XFER_COUNT sequence 1,2,3,0,1.

Source files
------------

// File: rtl/cdc_ctrl_pkg.sv
// Shared types and defaults for the REQ/ACK clock-domain-crossing controllers.
// The state encoding is fixed at 2 bits so the destination side can reuse it.
package cdc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2,
    ERROR       = 2'd3
  } state_t;

  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Phase timer width; the timer only ever counts up to cycles-1.
  function automatic int timer_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Used for ACK on the source side and REQ on the destination side.
module sync_ff_chain
  import cdc_ctrl_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/cdc_handshake_src_ctrl.sv
// Source-side 4-phase REQ/ACK controller: captures a producer word, holds it on
// XFER_DATA for the whole handshake, and flags a stalled destination by timeout.
module cdc_handshake_src_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   IN_VALID,
  input  logic [DATA_WIDTH-1:0]  IN_DATA,
  output logic                   IN_READY,
  output logic [DATA_WIDTH-1:0]  XFER_DATA,
  output logic                   XFER_REQ,
  input  logic                   XFER_ACK_ASYNC,
  input  logic                   ERR_CLEAR,
  output logic                   TIMEOUT_ERR,
  output logic                   BUSY,
  output logic [COUNT_WIDTH-1:0] XFER_COUNT
);

  localparam int TIMER_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic [DATA_WIDTH-1:0]  data_reg, data_next;
  logic                   req_reg, req_next;
  logic                   err_reg, err_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic                   ack_s;
  logic                   timer_expired;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (CLK),
    .rst_n(RESET_N),
    .d    (XFER_ACK_ASYNC),
    .q    (ack_s)
  );

  assign timer_expired = (timer_reg == TIMER_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      data_reg  <= '0;
      req_reg   <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      data_reg  <= data_next;
      req_reg   <= req_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    data_next  = data_reg;
    req_next   = req_reg;
    err_next   = err_reg;
    count_next = count_reg;

    case (state_reg)
      IDLE: begin
        if (IN_VALID) begin
          data_next  = IN_DATA;
          req_next   = 1'b1;
          state_next = WAIT_ACK_HI;
        end
      end
      // The awaited ack level is checked before the timeout so a level that
      // arrives on the last allowed cycle still completes the phase.
      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = WAIT_ACK_LO;
        end else if (timer_expired) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = ERROR;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          count_next = count_reg + 1'b1;
          state_next = IDLE;
        end else if (timer_expired) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = ERROR;
        end
      end
      ERROR: begin
        req_next = 1'b0;
        if (ERR_CLEAR && !ack_s) begin
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase

    // Staying in a wait state implies the timer has not reached its last value.
    if (state_next != state_reg) begin
      timer_next = '0;
    end else if (state_reg == WAIT_ACK_HI || state_reg == WAIT_ACK_LO) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  assign IN_READY    = (state_reg == IDLE);
  assign BUSY        = (state_reg != IDLE);
  assign XFER_DATA   = data_reg;
  assign XFER_REQ    = req_reg;
  assign TIMEOUT_ERR = err_reg;
  assign XFER_COUNT  = count_reg;

endmodule

// File: tb/tb_cdc_handshake_src_ctrl.sv
// Self-checking bench: per-cycle vector table, loopback bursts and random traffic
// against a transfer-timeline model, plus timeout, error-clear and reset sequences.
module tb_cdc_handshake_src_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        err_clear;
  logic        ack;
  logic        ack_man;
  logic        loopback;
  int          dly;
  logic [2:0]  req_pipe;

  logic        in_ready, xfer_req, timeout_err, busy;
  logic [7:0]  xfer_data;
  logic [15:0] xfer_count;
  logic        in_ready2, xfer_req2, timeout_err2, busy2;
  logic [7:0]  xfer_data2;
  logic [1:0]  xfer_count2;

  always #5 clk = ~clk;

  cdc_handshake_src_ctrl #(
    .DATA_WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(16)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data),
    .IN_READY(in_ready), .XFER_DATA(xfer_data), .XFER_REQ(xfer_req),
    .XFER_ACK_ASYNC(ack), .ERR_CLEAR(err_clear), .TIMEOUT_ERR(timeout_err),
    .BUSY(busy), .XFER_COUNT(xfer_count)
  );

  cdc_handshake_src_ctrl #(
    .DATA_WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(2)
  ) dut_w2 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data),
    .IN_READY(in_ready2), .XFER_DATA(xfer_data2), .XFER_REQ(xfer_req2),
    .XFER_ACK_ASYNC(ack), .ERR_CLEAR(err_clear), .TIMEOUT_ERR(timeout_err2),
    .BUSY(busy2), .XFER_COUNT(xfer_count2)
  );

  // Destination model: REQ looped back after dly cycles, or a manual level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_pipe <= '0;
    else        req_pipe <= {req_pipe[1:0], xfer_req};
  end

  always_comb begin
    ack = ack_man;
    if (loopback) begin
      case (dly)
        0:       ack = xfer_req;
        1:       ack = req_pipe[0];
        2:       ack = req_pipe[1];
        default: ack = req_pipe[2];
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted word keeps REQ high for dly+SYNC+1 cycles,
  // low for the same again, then the controller is idle on the next cycle.
  int         age = -1;
  logic [7:0] m_data;
  int         m_count;
  bit         accepted;

  task automatic model_edge();
    accepted = 1'b0;
    if (age < 0) begin
      if (in_valid) begin
        age      = 0;
        m_data   = in_data;
        accepted = 1'b1;
      end
    end else begin
      age++;
      if (age == 2 * (dly + SYNC + 1)) begin
        age = -1;
        m_count++;
      end
    end
  endtask

  task automatic check_model();
    logic er, eq;
    er = (age < 0);
    eq = (age >= 0) && (age < dly + SYNC + 1);
    check("ready",  32'(in_ready),    32'(er));
    check("busy",   32'(busy),        32'(!er));
    check("req",    32'(xfer_req),    32'(eq));
    check("data",   32'(xfer_data),   32'(m_data));
    check("count",  32'(xfer_count),  32'(m_count[15:0]));
    check("terr",   32'(timeout_err), 32'd0);
    check("ready2", 32'(in_ready2),   32'(er));
    check("busy2",  32'(busy2),       32'(!er));
    check("req2",   32'(xfer_req2),   32'(eq));
    check("data2",  32'(xfer_data2),  32'(m_data));
    check("count2", 32'(xfer_count2), 32'(m_count[1:0]));
    check("terr2",  32'(timeout_err2), 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        exp_req;
    logic        exp_rdy;
    logic [7:0]  exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] seen[$];
  logic       prev_req;
  int         idx;
  int         base;

  initial begin
    // 0xA5 with a 3-cycle destination delay: REQ high after edges 0..5,
    // ack_s low again by edge 12, so IDLE and count=1 from edge 12 on.
    for (int k = 0; k < 14; k++) vecs[k] = '{1'b1, 8'hFF, (k < 6), 1'b0, 8'hA5, 16'd0};
    vecs[0].d = 8'hA5;
    vecs[12]  = '{1'b1, 8'h77, 1'b0, 1'b1, 8'hA5, 16'd1};
    vecs[13]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 16'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clear = 1'b0;
    ack_man = 1'b0; loopback = 1'b0; dly = 0;
    m_count = 0; m_data = '0; age = -1;
    cyc(); cyc();
    check_model();
    rst_n = 1'b1;
    cyc();

    // Vector table
    loopback = 1'b1; dly = 3;
    for (int i = 0; i < 14; i++) begin
      in_valid = vecs[i].iv;
      in_data  = vecs[i].d;
      cyc();
      $display("vector %0d: iv=%0b d=%02h req=%0b rdy=%0b data=%02h cnt=%0d",
               i, vecs[i].iv, vecs[i].d, xfer_req, in_ready, xfer_data, xfer_count);
      check("vec_req",    32'(xfer_req),    32'(vecs[i].exp_req));
      check("vec_ready",  32'(in_ready),    32'(vecs[i].exp_rdy));
      check("vec_busy",   32'(busy),        32'(!vecs[i].exp_rdy));
      check("vec_data",   32'(xfer_data),   32'(vecs[i].exp_data));
      check("vec_count",  32'(xfer_count),  32'(vecs[i].exp_cnt));
      check("vec_count2", 32'(xfer_count2), 32'(vecs[i].exp_cnt[1:0]));
      check("vec_terr",   32'(timeout_err), 32'd0);
    end
    in_valid = 1'b0;
    m_count = 1; m_data = 8'hA5; age = -1;

    // Burst 0x01..0x08 under immediate loopback with IN_VALID held high
    dly = 0; idx = 0; base = m_count; prev_req = 1'b0;
    for (int c = 0; c < 200 && m_count < base + 8; c++) begin
      in_valid = (idx < 8);
      in_data  = 8'(idx + 1);
      tick();
      if (accepted) begin
        $display("burst xfer %0d data=%02h", idx, m_data);
        idx++;
      end
      check_model();
      if (xfer_req && !prev_req) seen.push_back(xfer_data);
      prev_req = xfer_req;
    end
    in_valid = 1'b0;
    check("burst_count", 32'(xfer_count), 32'(base + 8));
    check("burst_seen", 32'(seen.size()), 32'd8);
    for (int i = 0; i < seen.size() && i < 8; i++)
      check("burst_order", 32'(seen[i]), 32'(i + 1));

    // Random traffic with random destination delay
    for (int c = 0; c < 600; c++) begin
      if (age < 0 && $urandom_range(0, 5) == 0) dly = $urandom_range(0, 3);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      tick();
      if (accepted) $display("rand xfer data=%02h dly=%0d", m_data, dly);
      check_model();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 100 && age >= 0; c++) begin
      tick();
      check_model();
    end
    check("drain_idle", 32'(in_ready), 32'd1);

    // Timeout in WAIT_ACK_HI with ACK tied low
    loopback = 1'b0; ack_man = 1'b0; base = m_count;
    in_valid = 1'b1; in_data = 8'hC3;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      check("tmo_req_hi", 32'(xfer_req), 32'd1);
      check("tmo_err_lo", 32'(timeout_err), 32'd0);
      cyc();
    end
    $display("timeout xfer data=%02h terr=%0b", xfer_data, timeout_err);
    check("tmo_err",    32'(timeout_err), 32'd1);
    check("tmo_req",    32'(xfer_req),    32'd0);
    check("tmo_ready",  32'(in_ready),    32'd0);
    check("tmo_busy",   32'(busy),        32'd1);
    check("tmo_count",  32'(xfer_count),  32'(base[15:0]));
    check("tmo_count2", 32'(xfer_count2), 32'(base[1:0]));
    check("tmo_data",   32'(xfer_data),   32'hC3);

    // ERR_CLEAR with ack high is refused; with ack low it returns to IDLE
    ack_man = 1'b1;
    repeat (3) cyc();
    err_clear = 1'b1; cyc(); err_clear = 1'b0;
    check("clr_ackhi_err",   32'(timeout_err), 32'd1);
    check("clr_ackhi_ready", 32'(in_ready),    32'd0);
    ack_man = 1'b0;
    repeat (3) cyc();
    err_clear = 1'b1; cyc(); err_clear = 1'b0;
    check("clr_err",   32'(timeout_err), 32'd0);
    check("clr_ready", 32'(in_ready),    32'd1);
    check("clr_busy",  32'(busy),        32'd0);
    check("clr_req",   32'(xfer_req),    32'd0);

    // ack_s arrives exactly on the last timer cycle: handshake wins
    in_valid = 1'b1; in_data = 8'h96;
    cyc();
    in_valid = 1'b0;
    repeat (13) cyc();
    ack_man = 1'b1;
    cyc(); cyc();
    check("edge_req_hi", 32'(xfer_req), 32'd1);
    cyc();
    check("edge_req",   32'(xfer_req),    32'd0);
    check("edge_terr",  32'(timeout_err), 32'd0);
    check("edge_ready", 32'(in_ready),    32'd0);
    // Then ACK stuck high: WAIT_ACK_LO times out without counting
    repeat (TMO - 1) cyc();
    check("lo_terr_pre", 32'(timeout_err), 32'd0);
    cyc();
    $display("ack-low timeout data=%02h terr=%0b", xfer_data, timeout_err);
    check("lo_terr",  32'(timeout_err), 32'd1);
    check("lo_count", 32'(xfer_count),  32'(base[15:0]));
    ack_man = 1'b0;
    repeat (3) cyc();
    err_clear = 1'b1; cyc(); err_clear = 1'b0;
    check("lo_clr_ready", 32'(in_ready),    32'd1);
    check("lo_clr_terr",  32'(timeout_err), 32'd0);

    // Asynchronous reset in WAIT_ACK_HI with ACK toggling
    in_valid = 1'b1; in_data = 8'h5A;
    cyc();
    in_valid = 1'b0;
    ack_man = 1'b1;
    cyc();
    check("pre_rst_req",  32'(xfer_req),  32'd1);
    check("pre_rst_data", 32'(xfer_data), 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req",    32'(xfer_req),    32'd0);
    check("rst_data",   32'(xfer_data),   32'd0);
    check("rst_terr",   32'(timeout_err), 32'd0);
    check("rst_count",  32'(xfer_count),  32'd0);
    check("rst_count2", 32'(xfer_count2), 32'd0);
    check("rst_ready",  32'(in_ready),    32'd1);
    check("rst_busy",   32'(busy),        32'd0);
    @(negedge clk);
    repeat (2) begin
      ack_man = ~ack_man;
      cyc();
    end
    check("rst_hold_req", 32'(xfer_req), 32'd0);
    ack_man = 1'b0;
    rst_n = 1'b1;
    cyc();

    loopback = 1'b1; dly = 0;
    m_count = 0; m_data = '0; age = -1;
    check_model();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    if (accepted) $display("post-reset xfer data=%02h", m_data);
    check_model();
    for (int c = 0; c < 40 && age >= 0; c++) begin
      tick();
      check_model();
    end
    check("post_rst_count", 32'(xfer_count), 32'd1);
    check("post_rst_data",  32'(xfer_data),  32'h3C);
    check("post_rst_ready", 32'(in_ready),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
